// File: rtl/usb_gpx_pkg.sv
// Shared definitions for the GPX event controller.
// Register map, bit positions and sequencer states.
package usb_gpx_pkg;

    localparam logic [2:0] REG_LEVEL   = 3'd0;
    localparam logic [2:0] REG_CTRL    = 3'd1;
    localparam logic [2:0] REG_FLAGS   = 3'd2;
    localparam logic [2:0] REG_COUNT   = 3'd3;
    localparam logic [2:0] REG_TIMEOUT = 3'd4;
    localparam logic [2:0] REG_WAIT    = 3'd5;

    localparam int FLG_EDGE = 0;
    localparam int FLG_TMO  = 1;

    localparam int CTL_IRQ_EDGE = 0;
    localparam int CTL_IRQ_TMO  = 1;
    localparam int CTL_RISE     = 2;
    localparam int CTL_FALL     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HIT  = 2'd2,
        TMO  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/gpx_sync_filter.sv
// Two-flop synchroniser plus stability filter for the GPX pin.
// Emits the filtered level and one-cycle registered edge pulses.
module gpx_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic filt_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = 4;

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic          filt_d;
    logic          rise_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter tracks consecutive mismatch cycles; any match restarts it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            rise_q  <= filt_d & ~filt_q;
            fall_q  <= ~filt_d & filt_q;
        end
    end

    assign filt_o = filt_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/usb_gpx_event_ctrl.sv
// GPX pin event controller: edge capture, edge count, level IRQ
// and a one-shot wait-with-timeout sequencer on an Avalon-MM slave.
module usb_gpx_event_ctrl #(
    parameter int FILTER_LEN = 4,
    parameter int TMO_W      = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_port,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    import usb_gpx_pkg::*;

    logic             filt;
    logic             rise;
    logic             fall;
    logic             qual;
    logic [3:0]       ctrl_q;
    logic             edge_q;
    logic             edge_d;
    logic             tmo_q;
    logic             tmo_d;
    logic [15:0]      count_q;
    logic [15:0]      count_d;
    logic [TMO_W-1:0] timeout_q;
    logic [TMO_W-1:0] tcnt_q;
    logic [TMO_W-1:0] tcnt_d;
    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [31:0]      rdata;
    logic [31:0]      readdata_q;
    logic             wr_ctrl;
    logic             wr_flags;
    logic             wr_count;
    logic             wr_tmo;
    logic             arm;
    logic             unused_wd;

    gpx_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk    (clk),
        .reset_n(reset_n),
        .in_i   (in_port),
        .filt_o (filt),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign wr_ctrl  = write && (address == REG_CTRL);
    assign wr_flags = write && (address == REG_FLAGS);
    assign wr_count = write && (address == REG_COUNT);
    assign wr_tmo   = write && (address == REG_TIMEOUT);
    assign arm      = write && (address == REG_WAIT) && writedata[0];
    assign unused_wd = ^writedata;

    assign qual = (rise & ctrl_q[CTL_RISE]) | (fall & ctrl_q[CTL_FALL]);

    // Edge has priority over expiry when both land in the same cycle.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    if (timeout_q == '0) begin
                        state_d = TMO;
                    end else begin
                        state_d = WAIT;
                        tcnt_d  = timeout_q;
                    end
                end
            end
            WAIT: begin
                if (qual) begin
                    state_d = HIT;
                end else begin
                    tcnt_d = tcnt_q - TMO_W'(1);
                    if (tcnt_q == TMO_W'(1)) state_d = TMO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Setting a flag overrides a simultaneous write-one-to-clear.
    always_comb begin
        edge_d = qual | (edge_q & ~(wr_flags & writedata[FLG_EDGE]));
        tmo_d  = (state_q == TMO)
               | (tmo_q & ~(wr_flags & writedata[FLG_TMO]));
        count_d = count_q;
        if (wr_count) begin
            count_d = {15'd0, qual};
        end else if (qual && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_comb begin
        rdata = '0;
        case (address)
            REG_LEVEL:   rdata[0]   = filt;
            REG_CTRL:    rdata[3:0] = ctrl_q;
            REG_FLAGS:   rdata[1:0] = {tmo_q, edge_q};
            REG_COUNT:   rdata[15:0] = count_q;
            REG_TIMEOUT: rdata = 32'(timeout_q);
            REG_WAIT:    rdata[1:0] = state_q;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            edge_q     <= 1'b0;
            tmo_q      <= 1'b0;
            count_q    <= '0;
            timeout_q  <= '0;
            tcnt_q     <= '0;
            state_q    <= IDLE;
            readdata_q <= '0;
        end else begin
            edge_q  <= edge_d;
            tmo_q   <= tmo_d;
            count_q <= count_d;
            tcnt_q  <= tcnt_d;
            state_q <= state_d;
            if (wr_ctrl) ctrl_q <= writedata[3:0];
            if (wr_tmo) timeout_q <= writedata[TMO_W-1:0];
            if (read) readdata_q <= rdata;
        end
    end

    assign readdata = readdata_q;
    assign irq = (edge_q & ctrl_q[CTL_IRQ_EDGE])
               | (tmo_q & ctrl_q[CTL_IRQ_TMO]);

endmodule

// File: tb/tb_usb_gpx_event_ctrl.sv
// Scoreboard bench for usb_gpx_event_ctrl: behavioural model
// predicts reads and irq, a monitor compares against the DUT.
module tb_usb_gpx_event_ctrl;

    localparam int L  = 4;
    localparam int TW = 24;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_port = 1'b1;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    usb_gpx_event_ctrl #(
        .FILTER_LEN(L),
        .TMO_W(TW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .address  (address),
        .read     (read),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          hist[$];
    bit          m_filt, m_rise, m_fall;
    bit          m_eflag, m_tflag;
    logic [3:0]  m_ctrl;
    logic [15:0] m_count;
    logic [TW-1:0] m_tmo, m_cnt;
    int          m_state;
    bit          sat_req = 0;
    logic [34:0] exp_q[$];

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return {31'd0, m_filt};
            3'd1: return {28'd0, m_ctrl};
            3'd2: return {30'd0, m_tflag, m_eflag};
            3'd3: return {16'd0, m_count};
            3'd4: return 32'(m_tmo);
            3'd5: return 32'(m_state);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        bit flip, qual, tmo_set, arm, wf;
        int ns;
        if (!reset_n) begin
            m_filt = 0; m_rise = 0; m_fall = 0;
            m_eflag = 0; m_tflag = 0;
            m_ctrl = '0; m_count = '0;
            m_tmo = '0; m_cnt = '0; m_state = 0;
            hist.delete();
            for (int i = 0; i < L + 2; i++) hist.push_front(1'b0);
        end else begin
            if (read) exp_q.push_back({address, model_read(address)});
            qual = (m_rise && m_ctrl[2]) || (m_fall && m_ctrl[3]);
            // Level flips once the pin, two samples late, has shown
            // the opposite value for L consecutive samples.
            flip = 1;
            for (int i = 1; i <= L; i++)
                if (hist[i] == m_filt) flip = 0;
            hist.push_front(in_port);
            void'(hist.pop_back());
            m_rise = flip && !m_filt;
            m_fall = flip && m_filt;
            if (flip) m_filt = !m_filt;

            arm = write && address == 3'd5 && writedata[0];
            wf = write && address == 3'd2;
            tmo_set = (m_state == 3);
            ns = m_state;
            case (m_state)
                0: if (arm) begin
                    if (m_tmo == 0) ns = 3;
                    else begin ns = 1; m_cnt = m_tmo; end
                end
                1: if (qual) ns = 2;
                   else begin
                       m_cnt = m_cnt - 1;
                       if (m_cnt == 0) ns = 3;
                   end
                default: ns = 0;
            endcase
            m_state = ns;
            m_eflag = qual || (m_eflag && !(wf && writedata[0]));
            m_tflag = tmo_set || (m_tflag && !(wf && writedata[1]));
            if (write && address == 3'd3) m_count = {15'd0, qual};
            else if (qual && m_count != 16'hFFFF) m_count = m_count + 1;
            if (sat_req) m_count = 16'hFFFF;
            if (write && address == 3'd1) m_ctrl = writedata[3:0];
            if (write && address == 3'd4) m_tmo = writedata[TW-1:0];
        end
    end

    // ---------------- monitor ----------------
    logic rd_v;
    always @(posedge clk or negedge reset_n)
        if (!reset_n) rd_v <= 1'b0;
        else rd_v <= read;

    always @(negedge clk) begin : monitor
        logic [34:0] e;
        logic        m_irq;
        if (reset_n) begin
            if (rd_v) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_noexp got %h want <none>", readdata);
                end else begin
                    e = exp_q.pop_front();
                    if (readdata !== e[31:0]) begin
                        errors++;
                        $display("FAIL rd_a%0d got %h want %h t=%0t",
                                 e[34:32], readdata, e[31:0], $time);
                    end
                end
            end
            m_irq = (m_eflag && m_ctrl[0]) || (m_tflag && m_ctrl[1]);
            checks++;
            if (irq !== m_irq) begin
                errors++;
                $display("FAIL irq got %b want %b t=%0t",
                         irq, m_irq, $time);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input int n = 1);
        address = a; read = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        read = 1'b0;
    endtask

    initial begin
        int r;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got %h/%b want 0/0", readdata, irq);
        end
        reset_n = 1'b1;

        // Level follows the pin after filtering, no flag without rise_en.
        bus_read(3'd0);
        idle(L + 4);
        bus_read(3'd0);
        bus_read(3'd2);

        // Glitch rejection: short pulse ignored, long pulse counted.
        bus_write(3'd1, 32'h5);
        in_port = 0; idle(L + 6);
        in_port = 1; idle(L - 1);
        in_port = 0; idle(L + 6);
        bus_read(3'd2); bus_read(3'd3);
        in_port = 1; idle(8);
        in_port = 0; idle(L + 6);
        bus_read(3'd2); bus_read(3'd3);
        bus_write(3'd2, 32'h1);
        idle(2);

        // W1C racing a new edge, then COUNT clear racing an edge.
        for (int off = 0; off < 3; off++) begin
            bus_write(3'd2, 32'h3);
            in_port = 1; idle(L + off);
            bus_write(3'd2, 32'h1);
            idle(L + 4);
            bus_read(3'd2);
            in_port = 0; idle(L + 6);
        end
        for (int off = 0; off < 3; off++) begin
            in_port = 1; idle(L + off);
            bus_write(3'd3, 32'h0);
            idle(L + 4);
            bus_read(3'd3);
            in_port = 0; idle(L + 6);
        end

        // Plain timeout, then zero timeout.
        bus_write(3'd2, 32'h3);
        bus_write(3'd1, 32'h2);
        bus_write(3'd4, 32'd10);
        bus_write(3'd5, 32'h1);
        bus_read(3'd5, 14);
        bus_read(3'd2);
        bus_write(3'd2, 32'h2);
        bus_write(3'd4, 32'd0);
        bus_write(3'd5, 32'h1);
        bus_read(3'd5, 3);
        bus_read(3'd2);

        // Edge landing on the expiry cycle.
        bus_write(3'd1, 32'h7);
        bus_write(3'd4, 32'd10);
        for (int d = 2; d < 6; d++) begin
            bus_write(3'd2, 32'h3);
            bus_write(3'd5, 32'h1);
            idle(d);
            in_port = 1;
            bus_read(3'd5, 12);
            bus_read(3'd2);
            in_port = 0; idle(L + 6);
        end

        // Saturation at 0xFFFF.
        bus_write(3'd1, 32'h4);
        force dut.count_q = 16'hFFFF;
        sat_req = 1;
        idle(1);
        release dut.count_q;
        sat_req = 0;
        in_port = 1; idle(L + 6);
        bus_read(3'd3);
        in_port = 0; idle(L + 6);
        bus_read(3'd3);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) in_port = ~in_port;
            r = $urandom_range(0, 99);
            if (r < 30) begin
                bus_read(3'($urandom_range(0, 7)));
            end else if (r < 40) begin
                address = 3'($urandom_range(0, 7));
                case (address)
                    3'd4: writedata = $urandom_range(0, 20);
                    3'd5: writedata = $urandom_range(0, 1);
                    default: writedata = $urandom;
                endcase
                write = 1'b1;
                @(posedge clk); #1;
                write = 1'b0;
            end else begin
                idle(1);
            end
        end

        // Reset while waiting clears everything.
        bus_write(3'd4, 32'd1000);
        bus_write(3'd1, 32'hF);
        bus_write(3'd5, 32'h1);
        idle(5);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        for (int a = 0; a < 6; a++) bus_read(3'(a));
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
